// File: rtl/parity_serial_tx.sv
// Framing transmitter: accepts a word over valid/ready, then shifts out
// start bit, data LSB-first, parity bit and stop bit, each held CLKS_PER_BIT clocks.
module parity_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);
    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, and in_valid while not ready is dropped.

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic             ODD      = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic               parity_reg, parity_next;
    logic               tx_reg, tx_next;
    logic               bit_end;

    assign bit_end    = (clk_cnt == CLK_LAST);
    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end;
    assign tx_out     = tx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        tx_next      = 1'b1;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    shift_next   = in_data;
                    parity_next  = (^in_data) ^ ODD;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shift_next   = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = STOP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line value is registered from the next state so it changes with the state.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: three parameterisations (even/8/4,
// odd/8/4, even/3/1) driven from a vector table plus multi-cycle sequences.
module tb_parity_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_valid;
    logic [7:0] in_data [3];
    logic [2:0] in_ready;
    logic [2:0] tx_out;
    logic [2:0] busy;
    logic [2:0] frame_done;

    int n_vec;
    int n_fail;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    vec_t vecs [$];

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .tx_out(tx_out[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .tx_out(tx_out[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    parity_serial_tx #(.DATA_W(3), .CLKS_PER_BIT(1), .ODD_PARITY(0)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][2:0]), .tx_out(tx_out[2]), .busy(busy[2]), .frame_done(frame_done[2])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw_of(input int sel);
        return (sel == 2) ? 3 : 8;
    endfunction

    function automatic int cpb_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    // expected line value for bit slot idx of a frame
    function automatic logic exp_bit(input int sel, input logic [7:0] data,
                                     input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= dw_of(sel)) return data[idx-1];
        if (idx == dw_of(sel) + 1) return par;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        chk($sformatf("%s idle tx[%0d]", tag, sel), tx_out[sel], 1'b1);
        chk($sformatf("%s idle busy[%0d]", tag, sel), busy[sel], 1'b0);
        chk($sformatf("%s idle ready[%0d]", tag, sel), in_ready[sel], 1'b1);
        chk($sformatf("%s idle done[%0d]", tag, sel), frame_done[sel], 1'b0);
    endtask

    // present a word and return #1 after the accept edge
    task automatic send(input int sel, input logic [7:0] data);
        int waited;
        waited = 0;
        @(negedge clk);
        while (in_ready[sel] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("send ready wait[%0d]", sel), (waited < 200), 1'b1);
        in_data[sel]  = data;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
    endtask

    // checks every cycle of a frame that began at the preceding accept edge;
    // returns at the negedge of the last stop-bit cycle
    task automatic check_frame(input int sel, input logic [7:0] data, input logic par);
        int f_len;
        f_len = (dw_of(sel) + 3) * cpb_of(sel);
        for (int c = 0; c < f_len; c++) begin
            @(negedge clk);
            chk($sformatf("tx[%0d] d=%h c=%0d", sel, data, c), tx_out[sel],
                exp_bit(sel, data, par, c / cpb_of(sel)));
            chk($sformatf("busy[%0d] c=%0d", sel, c), busy[sel], 1'b1);
            chk($sformatf("ready[%0d] c=%0d", sel, c), in_ready[sel], 1'b0);
            chk($sformatf("done[%0d] c=%0d", sel, c), frame_done[sel], (c == f_len - 1));
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        in_valid = 3'b111;
        in_data[0] = 8'hA5;
        in_data[1] = 8'h5A;
        in_data[2] = 8'h07;
        rst_n    = 1'b0;

        vecs.push_back('{0, 8'hA5, 1'b0});
        vecs.push_back('{0, 8'h07, 1'b1});
        vecs.push_back('{0, 8'h3C, 1'b0});
        vecs.push_back('{1, 8'h00, 1'b1});
        vecs.push_back('{1, 8'hFF, 1'b1});
        vecs.push_back('{1, 8'h07, 1'b0});
        vecs.push_back('{2, 8'h00, 1'b0});
        vecs.push_back('{2, 8'h01, 1'b1});
        vecs.push_back('{2, 8'h02, 1'b1});
        vecs.push_back('{2, 8'h03, 1'b0});
        vecs.push_back('{2, 8'h04, 1'b1});
        vecs.push_back('{2, 8'h05, 1'b0});
        vecs.push_back('{2, 8'h06, 1'b0});
        vecs.push_back('{2, 8'h07, 1'b1});

        // reset held with in_valid asserted: nothing may start
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) check_idle(s, $sformatf("rst%0d", i));
        end
        in_valid = 3'b000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) check_idle(s, "post_rst");
        end

        // table-driven frames
        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].data);
            check_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_par);
            @(negedge clk);
            check_idle(vecs[i].sel, $sformatf("vec%0d", i));
        end

        // handshake: in_valid held, in_data changed mid-frame, back-to-back frames
        @(negedge clk);
        in_data[0]  = 8'h3C;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        fork
            check_frame(0, 8'h3C, 1'b0);
            begin
                repeat (10) @(posedge clk);
                #1 in_data[0] = 8'hFF;
            end
        join
        @(negedge clk);
        chk("b2b ready after done", in_ready[0], 1'b1);
        chk("b2b tx idle gap", tx_out[0], 1'b1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        check_frame(0, 8'hFF, 1'b0);
        @(negedge clk);
        check_idle(0, "b2b_end");

        // reset in the middle of data bit 3
        send(0, 8'h55);
        repeat (18) @(negedge clk);
        chk("pre_abort busy", busy[0], 1'b1);
        chk("pre_abort tx bit3", tx_out[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle(0, "abort_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (frame_done[0] === 1'b1 || tx_out[0] !== 1'b1) done_seen++;
            end
            chk("abort no stray activity", (done_seen == 0), 1'b1);
        end
        send(0, 8'h01);
        check_frame(0, 8'h01, 1'b1);
        @(negedge clk);
        check_idle(0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Parallel-to-serial framing transmitter that sits directly downstream of the parity generator stage. It accepts a data word through a valid/ready handshake and computes its parity bit (XOR reduction, even parity by default). It then shifts out a frame on a single line: start bit, data LSB-first, parity bit, stop bit. Each bit is held for a programmable number of clocks, so the line can feed a slower serial link.

Parameters:
DATA_W, 8, width of the data word (legal range 1..16)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (legal range 1..255)
ODD_PARITY, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (parity bit = inverted XOR)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream has a word on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  word to transmit
tx_out  output  1  serial line; idles high
busy  output  1  a frame is in progress
frame_done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tx_out=1, busy=0, frame_done=0, in_ready=1, bit and clock counters=0, data and parity registers=0.
- Reset asserted mid-frame: the frame is abandoned immediately, tx_out returns to 1 without waiting for a clock edge, and no frame_done pulse is produced.
- in_ready = (state==IDLE). This is combinational from the state register.
- Accept: on a rising edge where in_valid && in_ready:
  - in_data is latched into the shift register.
  - parity is computed from the latched value: ^in_data, inverted when ODD_PARITY=1.
  - state moves to START.
  - Later changes on in_data are ignored. in_valid while not ready is ignored, and the word is not queued.
- States and transitions (the clock counter counts 0..CLKS_PER_BIT-1 inside each bit and advances state on terminal count):
  - IDLE: tx_out=1, busy=0. Go to START on accept.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out = shift register bit 0. At each bit boundary the register shifts right and the bit counter increments. After DATA_W bits, go to PARITY.
  - PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle of STOP, then return to IDLE.
- busy=1 in every state except IDLE. tx_out is driven from a register (glitch-free).
- Latency: the first start-bit cycle on tx_out is the cycle after the accept edge. The frame occupies exactly (DATA_W+3)*CLKS_PER_BIT cycles.
- Back-to-back operation: in_ready rises the cycle after frame_done. The minimum spacing between frame starts is (DATA_W+3)*CLKS_PER_BIT+1 cycles.
- CLKS_PER_BIT=1: every bit lasts one cycle and there are no idle gaps inside the frame.
- Counter widths are sized from the parameters. The bit counter must not wrap before DATA_W is reached for DATA_W up to 16.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles while driving in_valid=1 -> tx_out=1, busy=0, in_ready=1, frame_done=0. No frame starts until rst_n rises.
- Even parity frame, default parameters, in_data=8'hA5 -> tx_out holds 0,1,0,1,0,0,1,0,1,0,1, each bit for 4 cycles. Parity bit is 0. Total 44 cycles. frame_done pulses at cycle 44.
- Odd-count data: in_data=8'h07 -> parity bit 1. With ODD_PARITY=1 and in_data=8'h00 -> parity bit 1. With ODD_PARITY=1 and in_data=8'hFF -> parity bit 1.
- Handshake: hold in_valid=1 with in_data=8'h3C, then change in_data to 8'hFF mid-frame -> first frame carries 8'h3C (parity 0). in_ready stays 0 until the cycle after frame_done. A second frame carrying 8'hFF (parity 0) starts the next cycle.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 8'h55 -> tx_out=1 and busy=0 immediately. No frame_done pulse. A following accept of 8'h01 gives a clean full frame with parity bit 1.
- CLKS_PER_BIT=1, DATA_W=3: sweep all 8 values -> 6-cycle frames. The parity bit equals x^y^z of the 3 bits, matching the upstream generator's truth table.
